// File: rtl/fetch_if.sv
// Bundle of the fetch front end's memory handshake, pipeline hand-off and redirect signals.
// The fetch unit uses the master side; memory and pipeline models use the slave side.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc_plus_4_out;
  logic        valid_out;

  modport master (
    output imem_req, imem_addr, instr_out, pc_plus_4_out, valid_out,
    input  imem_rvalid, imem_rdata, stall_in, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, pc_plus_4_out, valid_out,
    output imem_rvalid, imem_rdata, stall_in, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one request outstanding to instruction
// memory and hands each fetched word plus its PC+4 to the fetch-stage pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        req, req_n;
  logic [31:0] addr, addr_n;
  logic [31:0] instr, instr_n;
  logic [31:0] pc4, pc4_n;
  logic        valid, valid_n;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Wraps modulo 2^32, so the last word of the address space steps to 0.
  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ISSUE;
      pc    <= word_align(RESET_PC);
      req   <= 1'b0;
      addr  <= 32'd0;
      instr <= 32'd0;
      pc4   <= 32'd0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      req   <= req_n;
      addr  <= addr_n;
      instr <= instr_n;
      pc4   <= pc4_n;
      valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = 1'b0;
    addr_n  = addr;
    instr_n = instr;
    pc4_n   = pc4;
    valid_n = valid;

    if (bus.redirect_valid) begin
      // Redirect squashes the held instruction and any fetch in flight; a request
      // already sent to memory must have its response drained before re-issuing.
      pc_n    = word_align(bus.redirect_pc);
      valid_n = 1'b0;
      instr_n = 32'd0;
      pc4_n   = 32'd0;
      case (state)
        S_WAIT, S_DRAIN: state_n = bus.imem_rvalid ? S_ISSUE : S_DRAIN;
        default:         state_n = S_ISSUE;
      endcase
    end else begin
      case (state)
        S_ISSUE: begin
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            instr_n = bus.imem_rdata;
            pc4_n   = next_word(pc);
            pc_n    = next_word(pc);
            valid_n = 1'b1;
            state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          // Consuming the held word and issuing the next fetch share one cycle.
          if (!bus.stall_in) begin
            valid_n = 1'b0;
            req_n   = 1'b1;
            addr_n  = pc;
            state_n = S_WAIT;
          end
        end
        S_DRAIN: begin
          if (bus.imem_rvalid) state_n = S_ISSUE;
        end
        default: state_n = S_ISSUE;
      endcase
    end
  end

  assign bus.imem_req      = req;
  assign bus.imem_addr     = addr;
  assign bus.instr_out     = instr;
  assign bus.pc_plus_4_out = pc4;
  assign bus.valid_out     = valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stall/redirect/reset sequences with a queue of
// expected requests and instructions checked by an independent monitor.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();
  fetch_if bus2();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  int tests = 0;
  int fails = 0;

  logic [31:0] req_q[$];
  logic [63:0] ins_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model for dut: answers each request after mem_delay cycles.
  int          mem_delay = 1;
  int          cnt = 0;
  bit          pending = 0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] beef_addr = 32'h0000_0001;

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus.imem_rvalid = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          pending = 0;
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = (paddr == beef_addr) ? 32'hDEAD_BEEF : (paddr ^ 32'h0000_0013);
        end
      end
      if (bus.imem_req === 1'b1) begin
        pending = 1;
        cnt     = mem_delay;
        paddr   = bus.imem_addr;
      end
    end
  end

  // Memory model for dut2: fixed one-cycle latency, logs the last request address.
  bit          p2 = 0;
  logic [31:0] a2 = 32'd0;
  logic [31:0] req2_addr = 32'h1234_5678;

  initial begin
    bus2.imem_rvalid = 1'b0;
    bus2.imem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus2.imem_rvalid = 1'b0;
      if (p2) begin
        p2 = 0;
        bus2.imem_rvalid = 1'b1;
        bus2.imem_rdata  = a2 ^ 32'h0000_0013;
      end
      if (bus2.imem_req === 1'b1) begin
        p2        = 1;
        a2        = bus2.imem_addr;
        req2_addr = bus2.imem_addr;
      end
    end
  end

  // Monitor: every request and every newly presented instruction is matched to the queues.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (bus.imem_req === 1'b1) begin
      if (req_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_req: got addr %h expected no request", bus.imem_addr);
      end else begin
        check("req_addr", bus.imem_addr, req_q.pop_front());
      end
    end
    if (bus.valid_out === 1'b1 && !prev_v) begin
      if (ins_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_instr: got %h expected no instruction", bus.instr_out);
      end else begin
        logic [63:0] e;
        e = ins_q.pop_front();
        check("instr_out", bus.instr_out, e[63:32]);
        check("pc_plus_4_out", bus.pc_plus_4_out, e[31:0]);
      end
    end
    prev_v = (bus.valid_out === 1'b1);
  end

  task automatic wait_valid(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s: got no valid_out within %0d cycles expected valid_out=1", name, budget);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
    check({tag, "_addr"},  bus.imem_addr, 32'd0);
    check({tag, "_instr"}, bus.instr_out, 32'd0);
    check({tag, "_pc4"},   bus.pc_plus_4_out, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall_in = 1'b1;  bus.redirect_valid = 1'b0;  bus.redirect_pc = 32'd0;
    bus2.stall_in = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");

    // First fetch from RESET_PC=0.
    req_q.push_back(32'h0000_0000);
    ins_q.push_back({32'h0000_0013, 32'h0000_0004});
    rst = 1'b0;
    @(negedge clk);
    check("first_req_pulse", {31'd0, bus.imem_req}, 32'd1);
    wait_valid("first_instr", 10);

    // Stall holds everything.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, bus.valid_out}, 32'd1);
      check("stall_instr", bus.instr_out, 32'h0000_0013);
      check("stall_pc4",   bus.pc_plus_4_out, 32'h0000_0004);
      check("stall_req",   {31'd0, bus.imem_req}, 32'd0);
    end

    // dut2 wraps the address space.
    check("wrap_first_req", req2_addr, 32'hFFFF_FFFC);
    check("wrap_valid", {31'd0, bus2.valid_out}, 32'd1);
    check("wrap_instr", bus2.instr_out, 32'hFFFF_FFEF);
    check("wrap_pc4",   bus2.pc_plus_4_out, 32'h0000_0000);
    bus2.stall_in = 1'b0;
    @(negedge clk);
    bus2.stall_in = 1'b1;
    check("wrap_second_req", {31'd0, bus2.imem_req}, 32'd1);
    check("wrap_second_addr", bus2.imem_addr, 32'h0000_0000);

    // Release: consume and issue next fetch in the same cycle.
    req_q.push_back(32'h0000_0004);
    ins_q.push_back({32'h0000_0017, 32'h0000_0008});
    bus.stall_in = 1'b0;
    @(negedge clk);
    bus.stall_in = 1'b1;
    check("release_valid", {31'd0, bus.valid_out}, 32'd0);
    check("release_req", {31'd0, bus.imem_req}, 32'd1);
    wait_valid("second_instr", 10);

    // Redirect while waiting on a slow response that must never surface.
    beef_addr = 32'h0000_0008;
    mem_delay = 3;
    req_q.push_back(32'h0000_0008);
    bus.stall_in = 1'b0;
    @(negedge clk);
    bus.stall_in = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    req_q.push_back(32'h0000_0100);
    ins_q.push_back({32'h0000_0113, 32'h0000_0104});
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("redir_wait_valid", {31'd0, bus.valid_out}, 32'd0);
    check("redir_wait_instr", bus.instr_out, 32'd0);
    check("redir_wait_pc4",   bus.pc_plus_4_out, 32'd0);
    wait_valid("redir_wait_instr_arrives", 20);

    // Redirect in the same cycle as the response.
    mem_delay = 1;
    req_q.push_back(32'h0000_0104);
    bus.stall_in = 1'b0;
    @(negedge clk);
    bus.stall_in = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    req_q.push_back(32'h0000_0200);
    ins_q.push_back({32'h0000_0213, 32'h0000_0204});
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("redir_rv_valid", {31'd0, bus.valid_out}, 32'd0);
    check("redir_rv_instr", bus.instr_out, 32'd0);
    check("redir_rv_pc4",   bus.pc_plus_4_out, 32'd0);
    wait_valid("redir_rv_instr_arrives", 10);

    // Reset while in S_WAIT; the late response is ignored.
    req_q.push_back(32'h0000_0204);
    bus.stall_in = 1'b0;
    @(negedge clk);
    bus.stall_in = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midreset");
    req_q.push_back(32'h0000_0000);
    ins_q.push_back({32'h0000_0013, 32'h0000_0004});
    wait_valid("post_reset_instr", 10);

    // Redirect and stall together in S_HOLD: redirect wins.
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0302;
    req_q.push_back(32'h0000_0300);
    ins_q.push_back({32'h0000_0313, 32'h0000_0304});
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("redir_hold_valid", {31'd0, bus.valid_out}, 32'd0);
    check("redir_hold_instr", bus.instr_out, 32'd0);
    wait_valid("redir_hold_instr_arrives", 10);

    repeat (3) @(negedge clk);
    check("req_q_drained", req_q.size(), 32'd0);
    check("ins_q_drained", ins_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
